seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Purpose  : Time-multiplexes one shared 4-bit-to-7-segment decoder across
//             NUM_DIGITS common-anode digits. Each digit owns a slot of
//             REFRESH_DIV cycles. The first DEAD_CYC cycles of every slot keep
//             all digits off so the previous digit's pattern does not ghost.
//             Display contents arrive over a req/ack handshake into a shadow
//             buffer. The shadow is promoted to the active buffer only on the
//             frame-wrap edge, so a frame never tears.
//  Ports    : clk, rst_n        clock, synchronous active-low reset
//             upd_req/upd_ack   update handshake (ack = one-cycle pulse)
//             upd_data          4 bits per digit, digit i = [4i+3:4i]
//             upd_blank         1 = digit dark
//             busy              shadow holds data not yet applied
//             bcd               value for the shared segment decoder
//             dig_n             active-low digit enables
//             frame_start       pulse in the first cycle of slot 0
//  Option   : `define SEG_BLINK_EN adds the BLINK_FRAMES parameter, the
//             blink_mask input (double-buffered) and the blink_phase output.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int DEAD_CYC     = 4
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 32
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      upd_req,
    input  logic [4*NUM_DIGITS-1:0]   upd_data,
    input  logic [NUM_DIGITS-1:0]     upd_blank,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic                      blink_phase,
`endif
    output logic                      upd_ack,
    output logic                      busy,
    output logic [3:0]                bcd,
    output logic [NUM_DIGITS-1:0]     dig_n,
    output logic                      frame_start
);

    localparam int c_DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(REFRESH_DIV - 1);
    localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(NUM_DIGITS - 1);
    localparam logic [c_DW-1:0] c_DEAD     = c_DW'(DEAD_CYC);

`ifdef SEG_BLINK_EN
    localparam int              c_BW         = $clog2(BLINK_FRAMES + 1);
    localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_FRAMES - 1);
`endif

    // Scan position. r_run is low for the first cycle after reset so the
    // counters hold at 0 once and every registered output can be computed
    // from the next-cycle position: outputs then line up with div_cnt/dig_idx.
    logic                    r_run;
    logic [c_DW-1:0]         r_div_cnt;
    logic [c_IW-1:0]         r_dig_idx;

    logic [4*NUM_DIGITS-1:0] r_active_data;
    logic [NUM_DIGITS-1:0]   r_active_blank;
    logic [4*NUM_DIGITS-1:0] r_shadow_data;
    logic [NUM_DIGITS-1:0]   r_shadow_blank;

`ifdef SEG_BLINK_EN
    logic [NUM_DIGITS-1:0]   r_active_mask;
    logic [NUM_DIGITS-1:0]   r_shadow_mask;
    logic [c_BW-1:0]         r_blink_cnt;
    logic                    w_phase_nxt;
    logic [NUM_DIGITS-1:0]   w_mask_nxt;
`endif

    logic                    w_slot_wrap;
    logic                    w_frame_wrap;
    logic                    w_apply;
    logic                    w_capture;
    logic [c_DW-1:0]         w_div_nxt;
    logic [c_IW-1:0]         w_idx_nxt;
    logic [4*NUM_DIGITS-1:0] w_data_nxt;
    logic [NUM_DIGITS-1:0]   w_blank_nxt;
    logic [NUM_DIGITS-1:0]   w_blank_eff;
    logic [3:0]              w_bcd_nxt;
    logic                    w_blank_sel;
    logic [NUM_DIGITS-1:0]   w_dign_nxt;

    always_comb begin
        w_slot_wrap  = r_run && (r_div_cnt == c_DIV_LAST);
        w_frame_wrap = w_slot_wrap && (r_dig_idx == c_IDX_LAST);
        // Apply and capture are mutually exclusive through busy, so a request
        // seen on the frame-wrap edge with busy=0 is only captured there.
        w_apply      = w_frame_wrap && busy;
        w_capture    = upd_req && !busy && !upd_ack;

        if (!r_run || w_slot_wrap) begin
            w_div_nxt = '0;
        end else begin
            w_div_nxt = r_div_cnt + 1'b1;
        end

        if (w_slot_wrap) begin
            w_idx_nxt = (r_dig_idx == c_IDX_LAST) ? '0 : r_dig_idx + 1'b1;
        end else begin
            w_idx_nxt = r_dig_idx;
        end

        // Buffer contents as they will be after this edge; the shadow is
        // forwarded so slot 0 of the new frame already shows the new data.
        w_data_nxt  = w_apply ? r_shadow_data  : r_active_data;
        w_blank_nxt = w_apply ? r_shadow_blank : r_active_blank;

`ifdef SEG_BLINK_EN
        w_mask_nxt  = w_apply ? r_shadow_mask : r_active_mask;
        w_phase_nxt = blink_phase;
        if (w_frame_wrap && (r_blink_cnt == c_BLINK_LAST)) begin
            w_phase_nxt = ~blink_phase;
        end
        w_blank_eff = w_blank_nxt | (w_mask_nxt & {NUM_DIGITS{~w_phase_nxt}});
`else
        w_blank_eff = w_blank_nxt;
`endif

        w_bcd_nxt   = 4'd0;
        w_blank_sel = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (c_IW'(i) == w_idx_nxt) begin
                w_bcd_nxt   = w_data_nxt[4*i +: 4];
                w_blank_sel = w_blank_eff[i];
            end
        end

        // One-hot-low enable, all off during dead time or when blanked.
        w_dign_nxt = '1;
        if ((w_div_nxt >= c_DEAD) && !w_blank_sel) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (c_IW'(i) == w_idx_nxt) begin
                    w_dign_nxt[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run          <= 1'b0;
            r_div_cnt      <= '0;
            r_dig_idx      <= '0;
            r_active_data  <= '0;
            r_active_blank <= '1;
            r_shadow_data  <= '0;
            r_shadow_blank <= '0;
            busy           <= 1'b0;
            upd_ack        <= 1'b0;
            bcd            <= 4'd0;
            dig_n          <= '1;
            frame_start    <= 1'b0;
        end else begin
            r_run     <= 1'b1;
            r_div_cnt <= w_div_nxt;
            r_dig_idx <= w_idx_nxt;

            if (w_apply) begin
                r_active_data  <= r_shadow_data;
                r_active_blank <= r_shadow_blank;
                busy           <= 1'b0;
            end else if (w_capture) begin
                r_shadow_data  <= upd_data;
                r_shadow_blank <= upd_blank;
                busy           <= 1'b1;
            end

            upd_ack     <= w_apply;
            frame_start <= (w_div_nxt == '0) && (w_idx_nxt == '0);
            if (w_div_nxt == '0) begin
                bcd <= w_bcd_nxt;
            end
            dig_n <= w_dign_nxt;
        end
    end

`ifdef SEG_BLINK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active_mask <= '0;
            r_shadow_mask <= '0;
            r_blink_cnt   <= '0;
            blink_phase   <= 1'b1;
        end else begin
            if (w_apply) begin
                r_active_mask <= r_shadow_mask;
            end else if (w_capture) begin
                r_shadow_mask <= blink_mask;
            end
            if (w_frame_wrap) begin
                r_blink_cnt <= (r_blink_cnt == c_BLINK_LAST) ? '0 : r_blink_cnt + 1'b1;
            end
            blink_phase <= w_phase_nxt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_ctrl
//  Purpose  : Self-checking bench for seg_scan_ctrl with NUM_DIGITS=4,
//             REFRESH_DIV=8, DEAD_CYC=2 (one frame = 32 cycles). Stimulus
//             pushes expected updates (ack position, data, blank) into a
//             queue; a monitor checks every cycle against the position
//             counted from reset release and pops entries on upd_ack.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int c_ND = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            upd_req;
    logic [15:0]     upd_data;
    logic [3:0]      upd_blank;
    logic            upd_ack;
    logic            busy;
    logic [3:0]      bcd;
    logic [3:0]      dig_n;
    logic            frame_start;
`ifdef SEG_BLINK_EN
    logic            blink_phase;
`endif

    typedef struct packed {
        int          ack_pos;
        logic [15:0] data;
        logic [3:0]  blank;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_data  = 16'h0;
    logic [3:0]  exp_blank = 4'hF;
    int          pos       = -1;
    int          checks    = 0;
    int          failures  = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS  (c_ND),
        .REFRESH_DIV (8),
        .DEAD_CYC    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .upd_req     (upd_req),
        .upd_data    (upd_data),
        .upd_blank   (upd_blank),
`ifdef SEG_BLINK_EN
        .blink_mask  (4'b0000),
        .blink_phase (blink_phase),
`endif
        .upd_ack     (upd_ack),
        .busy        (busy),
        .bcd         (bcd),
        .dig_n       (dig_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Cycle position since reset release: 0 is the first cycle of slot 0.
    always @(posedge clk) begin
        if (!rst_n) pos <= -1;
        else        pos <= pos + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s pos=%0d actual=%0h required=%0h", name, pos, act, req);
        end
    endtask

    task automatic goto(input int p);
        int n = 0;
        while (pos != p && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (pos != p) begin
            checks++;
            failures++;
            $display("FAIL goto actual=%0d required=%0d", pos, p);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        int   slot;
        int   d;
        exp_t e;
        logic [3:0] want_dn;
        if (pos < 0) begin
            exp_data  = 16'h0;
            exp_blank = 4'hF;
        end else begin
            chk("upd_ack", {31'd0, upd_ack},
                {31'd0, (exp_q.size() > 0) && (exp_q[0].ack_pos == pos)});
            if (upd_ack && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_data  = e.data;
                exp_blank = e.blank;
            end
            slot = (pos / 8) % 4;
            d    = pos % 8;
            chk("frame_start", {31'd0, frame_start}, {31'd0, (pos % 32) == 0});
            chk("bcd", {28'd0, bcd}, {28'd0, exp_data[slot*4 +: 4]});
            want_dn = 4'hF;
            if (d >= 2 && !exp_blank[slot]) want_dn[slot] = 1'b0;
            chk("dig_n", {28'd0, dig_n}, {28'd0, want_dn});
        end
    end

    initial begin
        rst_n     = 1'b0;
        upd_req   = 1'b0;
        upd_data  = 16'h0;
        upd_blank = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dig_n", {28'd0, dig_n}, 32'hF);
        chk("rst_bcd", {28'd0, bcd}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_ack", {31'd0, upd_ack}, 32'h0);
        chk("rst_frame_start", {31'd0, frame_start}, 32'h0);
        rst_n = 1'b1;

        // Frame 0 stays dark; update 4321 requested in frame 1.
        goto(33);
        upd_data  = 16'h4321;
        upd_blank = 4'b0000;
        upd_req   = 1'b1;
        exp_q.push_back('{64, 16'h4321, 4'b0000});
        goto(34);
        chk("busy_capture", {31'd0, busy}, 32'h1);
        // Next request presented while busy: must wait for the ack.
        upd_data = 16'hAAAA;
        exp_q.push_back('{96, 16'hAAAA, 4'b0000});
        goto(65);
        chk("busy_after_ack", {31'd0, busy}, 32'h0);
        goto(66);
        chk("busy_recapture", {31'd0, busy}, 32'h1);
        goto(96);
        upd_req = 1'b0;
        goto(97);
        chk("busy_idle", {31'd0, busy}, 32'h0);

        // Blank digit 2.
        goto(100);
        upd_data  = 16'h4321;
        upd_blank = 4'b0100;
        upd_req   = 1'b1;
        exp_q.push_back('{128, 16'h4321, 4'b0100});
        goto(128);
        upd_req = 1'b0;

        // Request raised exactly in the frame-wrap cycle.
        goto(159);
        upd_data  = 16'h9876;
        upd_blank = 4'b0000;
        upd_req   = 1'b1;
        exp_q.push_back('{192, 16'h9876, 4'b0000});
        goto(160);
        chk("wrap_busy", {31'd0, busy}, 32'h1);
        chk("wrap_no_ack", {31'd0, upd_ack}, 32'h0);
        goto(192);
        // Held over the ack: a new request with new data.
        upd_data  = 16'h1357;
        upd_blank = 4'b1000;
        exp_q.push_back('{224, 16'h1357, 4'b1000});
        goto(194);
        chk("held_recapture", {31'd0, busy}, 32'h1);

        // Mid-slot reset with an update pending.
        goto(200);
        chk("busy_before_rst", {31'd0, busy}, 32'h1);
        rst_n   = 1'b0;
        upd_req = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("mid_rst_dig_n", {28'd0, dig_n}, 32'hF);
        chk("mid_rst_bcd", {28'd0, bcd}, 32'h0);
        chk("mid_rst_busy", {31'd0, busy}, 32'h0);
        chk("mid_rst_ack", {31'd0, upd_ack}, 32'h0);
        chk("mid_rst_frame_start", {31'd0, frame_start}, 32'h0);
        rst_n = 1'b1;
        goto(40);
        chk("queue_empty", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
